// File: rtl/lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer
//
// MEM-stage micro-sequencer for the 16-bit RISC pipeline. An LM/SM instruction
// sitting in EX/MEM is expanded into one register<->memory word transfer per
// clock. While the transfers run, the front of the pipeline (PC .. EX/MEM) is
// held with `stall`. All other instructions pass straight through, and only
// plain SW produces a data-memory write strobe.
//
// Parameters
//   OPC_LM     opcode of load-multiple
//   OPC_SM     opcode of store-multiple
//   OPC_SW     opcode of plain store-word
//   ADDR_STEP  address increment per transferred register
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   EX_MEM_IR     instruction in EX/MEM: [15:12] opcode, [7:0] register mask
//   ex_mem_valid  EX_MEM_IR holds a live instruction
//   base_addr     start address (ALU result), also the plain load/store address
//   rf_rd_data    register-file read data for rf_rd_addr
//   mem_rd_data   data-memory read data for mem_addr (same cycle)
//   mem_addr      data-memory address
//   MEM_WR_EN     data-memory write strobe
//   mem_wr_data   data-memory write data
//   rf_rd_addr    register-file read index
//   rf_wr_en      register-file write enable (LM only)
//   rf_wr_addr    register-file write index
//   rf_wr_data    register-file write data
//   stall         hold PC, IF/ID, ID/RR, RR/EX, EX/MEM this cycle
//   busy          sequencer is in the transfer state
//   done          one-cycle pulse after an LM/SM completes
// -----------------------------------------------------------------------------
module lm_sm_sequencer #(
    parameter logic [3:0]  OPC_LM    = 4'b0110,
    parameter logic [3:0]  OPC_SM    = 4'b0111,
    parameter logic [3:0]  OPC_SW    = 4'b0101,
    parameter logic [15:0] ADDR_STEP = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] EX_MEM_IR,
    input  logic        ex_mem_valid,
    input  logic [15:0] base_addr,
    input  logic [15:0] rf_rd_data,
    input  logic [15:0] mem_rd_data,
    output logic [15:0] mem_addr,
    output logic        MEM_WR_EN,
    output logic [15:0] mem_wr_data,
    output logic [2:0]  rf_rd_addr,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_addr,
    output logic [15:0] rf_wr_data,
    output logic        stall,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] addr_q, addr_d;
    logic        is_lm_q, is_lm_d;
    logic        done_q, done_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [3:0] opcode;
    logic [7:0] ir_mask;
    logic [2:0] ir_ra;
    logic       is_multi;
    logic       start;
    logic       start_xfer;
    logic       unused_ir_bit;

    assign opcode   = EX_MEM_IR[15:12];
    assign ir_mask  = EX_MEM_IR[7:0];
    // A plain SW stores the register named in [11:9]; its value is read
    // through the same register-file port that SM uses.
    assign ir_ra    = EX_MEM_IR[11:9];
    assign unused_ir_bit = EX_MEM_IR[8];

    assign is_multi   = (opcode == OPC_LM) || (opcode == OPC_SM);
    assign start      = (state_q == ST_IDLE) && ex_mem_valid && is_multi;
    assign start_xfer = start && (ir_mask != 8'h00);

    // ------------------------------------------------------------------
    // Lowest-pending-register priority encoder.
    // Mask bit 7 is R0, bit 0 is R7, so the lowest register is the highest
    // set bit. higher[gi] says some bit above gi is still pending; the
    // selected bit is the set bit with nothing pending above it.
    // ------------------------------------------------------------------
    logic [7:0] higher;
    logic [7:0] sel;
    logic [7:0] remaining;
    logic [2:0] cur_reg;
    logic       last_xfer;

    assign higher[7] = 1'b0;
    for (genvar gi = 0; gi < 7; gi++) begin : g_higher
        assign higher[gi] = |mask_q[7:gi+1];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
        assign sel[gi] = mask_q[gi] & ~higher[gi];
    end

    // Every pending bit except the selected one has a pending bit above it.
    assign remaining = mask_q & higher;

    always_comb begin
        cur_reg = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                cur_reg = 3'(7 - i);
            end
        end
    end

    // An empty mask in XFER cannot normally occur; treating it as the last
    // cycle guarantees the sequencer always drains back to IDLE.
    assign last_xfer = (state_q == ST_XFER) && (remaining == 8'h00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= 8'h00;
            addr_q  <= 16'h0000;
            is_lm_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            is_lm_q <= is_lm_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        is_lm_d = is_lm_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ir_mask != 8'h00) begin
                        mask_d  = ir_mask;
                        addr_d  = base_addr;
                        is_lm_d = (opcode == OPC_LM);
                        state_d = ST_XFER;
                    end else begin
                        // Nothing to move: complete immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                mask_d = remaining;
                addr_d = addr_q + ADDR_STEP;   // wraps modulo 2^16
                if (last_xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Everything is forced low while reset is asserted so that no
    // strobe can fire from the combinational bypass path during reset.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr    = 16'h0000;
        MEM_WR_EN   = 1'b0;
        mem_wr_data = 16'h0000;
        rf_rd_addr  = 3'd0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = 3'd0;
        rf_wr_data  = 16'h0000;
        stall       = 1'b0;
        busy        = 1'b0;

        if (rst_n) begin
            if (state_q == ST_XFER) begin
                mem_addr = addr_q;
                busy     = 1'b1;
                // Releasing stall on the final transfer lets the next
                // instruction reach EX/MEM exactly as the sequencer returns
                // to IDLE.
                stall    = ~last_xfer;
                if (is_lm_q) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = cur_reg;
                    rf_wr_data = mem_rd_data;
                end else begin
                    rf_rd_addr  = cur_reg;
                    MEM_WR_EN   = 1'b1;
                    mem_wr_data = rf_rd_data;
                end
            end else begin
                mem_addr    = base_addr;
                rf_rd_addr  = ir_ra;
                mem_wr_data = rf_rd_data;
                MEM_WR_EN   = ex_mem_valid && (opcode == OPC_SW);
                // The accept cycle only latches; the pipeline must hold so
                // the LM/SM stays in EX/MEM while it is expanded.
                stall       = start_xfer;
            end
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] EX_MEM_IR;
    logic        ex_mem_valid;
    logic [15:0] base_addr;
    logic [15:0] rf_rd_data;
    logic [15:0] mem_rd_data;
    logic [15:0] mem_addr;
    logic        MEM_WR_EN;
    logic [15:0] mem_wr_data;
    logic [2:0]  rf_rd_addr;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        stall;
    logic        busy;
    logic        done;

    int compared   = 0;
    int mismatched = 0;
    logic armed = 1'b0;

    lm_sm_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EX_MEM_IR    (EX_MEM_IR),
        .ex_mem_valid (ex_mem_valid),
        .base_addr    (base_addr),
        .rf_rd_data   (rf_rd_data),
        .mem_rd_data  (mem_rd_data),
        .mem_addr     (mem_addr),
        .MEM_WR_EN    (MEM_WR_EN),
        .mem_wr_data  (mem_wr_data),
        .rf_rd_addr   (rf_rd_addr),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .stall        (stall),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns 0xA000 + address; register Rn holds 0xC0D0 | n.
    assign mem_rd_data = 16'hA000 + mem_addr;
    assign rf_rd_data  = 16'hC0D0 | {13'd0, rf_rd_addr};

    // Control bundle: {stall, busy, MEM_WR_EN, rf_wr_en, done}
    logic [4:0] ctl;
    assign ctl = {stall, busy, MEM_WR_EN, rf_wr_en, done};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait to mid-cycle, then check the control bundle and the address.
    task automatic expect_cyc(input string tag, input logic [4:0] c, input logic [15:0] a);
        @(negedge clk);
        check({tag, " ctl"}, 16'(ctl), 16'(c));
        check({tag, " addr"}, mem_addr, a);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ir, input logic [15:0] base);
        EX_MEM_IR    = ir;
        base_addr    = base;
        ex_mem_valid = 1'b1;
    endtask

    // Strobes are mutually exclusive and never unknown once out of reset.
    always @(negedge clk) begin
        if (armed && rst_n) begin
            compared++;
            assert (!(MEM_WR_EN && rf_wr_en) && !$isunknown({ctl, mem_addr, rf_wr_addr, rf_rd_addr})) else begin
                mismatched++;
                $error("FAIL invariant: observed ctl %b expected no X and not both write enables", ctl);
            end
        end
    end

    initial begin
        logic s;
        // ---------------- Reset: outputs forced low even with a live SW ----
        rst_n        = 1'b0;
        EX_MEM_IR    = 16'h5000;
        ex_mem_valid = 1'b1;
        base_addr    = 16'h1234;
        expect_cyc("reset", 5'b00000, 16'h0000);
        check("reset addr_q", dut.addr_q, 16'h0000);
        check("reset mask_q", 16'(dut.mask_q), 16'h0000);
        adv();
        rst_n        = 1'b1;
        ex_mem_valid = 1'b0;
        EX_MEM_IR    = 16'h0000;
        base_addr    = 16'h0055;
        armed        = 1'b1;
        expect_cyc("idle", 5'b00000, 16'h0055);
        adv();
        $display("reset / idle done");

        // ---------------- Test 1: SM mask A0 base 0040 ----------------------
        issue(16'h70A0, 16'h0040);
        expect_cyc("t1 accept", 5'b10000, 16'h0040);
        adv();
        expect_cyc("t1 x1", 5'b11100, 16'h0040);
        check("t1 x1 rd_addr", 16'(rf_rd_addr), 16'd0);
        check("t1 x1 wdata", mem_wr_data, 16'hC0D0);
        adv();
        expect_cyc("t1 x2", 5'b01100, 16'h0041);
        check("t1 x2 rd_addr", 16'(rf_rd_addr), 16'd2);
        check("t1 x2 wdata", mem_wr_data, 16'hC0D2);
        adv();
        ex_mem_valid = 1'b0;
        expect_cyc("t1 done", 5'b00001, 16'h0040);
        adv();
        expect_cyc("t1 after", 5'b00000, 16'h0040);
        adv();
        $display("test1 SM mask=A0 base=0040 finished");

        // ---------------- Test 2: LM mask FF base 0100 ----------------------
        issue(16'h60FF, 16'h0100);
        expect_cyc("t2 accept", 5'b10000, 16'h0100);
        adv();
        for (int i = 0; i < 8; i++) begin
            s = (i < 7);
            expect_cyc($sformatf("t2 x%0d", i), {s, 4'b1010}, 16'h0100 + 16'(i));
            check($sformatf("t2 x%0d wr_addr", i), 16'(rf_wr_addr), 16'(i));
            check($sformatf("t2 x%0d wr_data", i), rf_wr_data, 16'hA100 + 16'(i));
            adv();
        end
        ex_mem_valid = 1'b0;
        expect_cyc("t2 done", 5'b00001, 16'h0100);
        adv();
        $display("test2 LM mask=FF base=0100 finished");

        // ---------------- Test 3: LM mask 01 base FFFF (wrap) ---------------
        issue(16'h6001, 16'hFFFF);
        expect_cyc("t3 accept", 5'b10000, 16'hFFFF);
        adv();
        expect_cyc("t3 x1", 5'b01010, 16'hFFFF);
        check("t3 wr_addr", 16'(rf_wr_addr), 16'd7);
        check("t3 wr_data", rf_wr_data, 16'h9FFF);
        adv();
        ex_mem_valid = 1'b0;
        expect_cyc("t3 done", 5'b00001, 16'hFFFF);
        check("t3 addr_q wrap", dut.addr_q, 16'h0000);
        adv();
        $display("test3 LM mask=01 base=FFFF finished");

        // ---------------- Test 4: SM empty mask -----------------------------
        issue(16'h7000, 16'h0060);
        expect_cyc("t4 start", 5'b00000, 16'h0060);
        adv();
        ex_mem_valid = 1'b0;
        expect_cyc("t4 done", 5'b00001, 16'h0060);
        adv();
        expect_cyc("t4 after", 5'b00000, 16'h0060);
        adv();
        $display("test4 SM mask=00 finished");

        // ---------------- Test 5: LM mask F0, reset after 2nd transfer ------
        issue(16'h60F0, 16'h0200);
        expect_cyc("t5 accept", 5'b10000, 16'h0200);
        adv();
        expect_cyc("t5 x1", 5'b11010, 16'h0200);
        check("t5 x1 wr_addr", 16'(rf_wr_addr), 16'd0);
        check("t5 x1 wr_data", rf_wr_data, 16'hA200);
        adv();
        expect_cyc("t5 x2", 5'b11010, 16'h0201);
        check("t5 x2 wr_addr", 16'(rf_wr_addr), 16'd1);
        check("t5 x2 wr_data", rf_wr_data, 16'hA201);
        adv();
        rst_n        = 1'b0;
        ex_mem_valid = 1'b0;
        #1;
        check("t5 reset ctl", 16'(ctl), 16'h0000);
        check("t5 reset addr", mem_addr, 16'h0000);
        check("t5 reset wr_data", rf_wr_data, 16'h0000);
        adv();
        rst_n = 1'b1;
        expect_cyc("t5 released", 5'b00000, 16'h0200);
        adv();
        expect_cyc("t5 idle", 5'b00000, 16'h0200);
        adv();
        $display("test5 LM mask=F0 aborted by reset finished");

        // ---------------- Test 6: ADD, SW, SM(03), then LM back to back ----
        issue(16'h0000, 16'h0300);
        expect_cyc("t6 add", 5'b00000, 16'h0300);
        adv();
        issue(16'h5000, 16'h0310);
        expect_cyc("t6 sw", 5'b00100, 16'h0310);
        adv();
        issue(16'h7003, 16'h0320);
        expect_cyc("t6 sm accept", 5'b10000, 16'h0320);
        adv();
        expect_cyc("t6 sm x1", 5'b11100, 16'h0320);
        check("t6 x1 rd_addr", 16'(rf_rd_addr), 16'd6);
        check("t6 x1 wdata", mem_wr_data, 16'hC0D6);
        adv();
        expect_cyc("t6 sm x2", 5'b01100, 16'h0321);
        check("t6 x2 rd_addr", 16'(rf_rd_addr), 16'd7);
        check("t6 x2 wdata", mem_wr_data, 16'hC0D7);
        adv();
        // Pipeline advanced: LM mask 80 arrives while done is high.
        issue(16'h6080, 16'h0400);
        expect_cyc("t6 lm accept+done", 5'b10001, 16'h0400);
        adv();
        ex_mem_valid = 1'b0;
        expect_cyc("t6 lm x1", 5'b01010, 16'h0400);
        check("t6 lm wr_addr", 16'(rf_wr_addr), 16'd0);
        check("t6 lm wr_data", rf_wr_data, 16'hA400);
        adv();
        expect_cyc("t6 lm done", 5'b00001, 16'h0400);
        adv();
        $display("test6 ADD/SW/SM/LM sequence finished");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
